pipelined_cpu: RTL and testbench
================================

# pipelined_cpu

Five-stage in-order MIPS-subset processor (IF, ID, EX, MEM, WB) with internal instruction memory, data memory and register file. It is the top of the project and has no data ports: programs and data are preloaded through hierarchical access, and results are read back from the register file and data memory. Load-use stalls are handled by a hazard unit, data hazards by forwarding, and branches and jumps resolve in ID with a one-slot flush.

## Interface
- No parameters. Storage sizes are fixed: instruction memory 256 x 32-bit words; data memory 32 x 8-bit bytes; register file 32 x 32-bit.
- clk_i  input  1  system clock, rising-edge active.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  run enable; PC advances only while high.
- Bench-visible state: instance Instruction_Memory holds array memory[0:255]; instance Data_Memory holds array memory[0:31]; instance Registers holds array register[0:31]; instance PC exposes pc_o.

## Operation
- Instruction memory is word-indexed by PC[9:2]. Data memory is byte-addressed and little-endian; a word at address A occupies bytes A..A+3, with A+0 as the LSB.
- Supported instructions, standard MIPS encodings:
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, mul 0x18. mul writes the low 32 bits of the product to rd.
  - addi (0x08): sign-extended immediate.
  - lw (0x23) and sw (0x2B): address = rs + sext(imm).
  - beq (0x04): target = PC+4 + (sext(imm)<<2).
  - j (0x02): target = {PC+4[31:28], addr26, 2'b00}.
  - The all-zero word is a NOP.
  - Any other opcode is a NOP, with no write and no memory access.
- No overflow exceptions. Writes to r0 are discarded; r0 always reads 0.
- Register file writes at the clock edge. A read in ID of a register being written in WB the same cycle returns the new value.
- Forwarding for ALU operands A and B in EX:
  - EX/MEM has priority when its RegWrite is set, rd != 0 and rd matches.
  - Otherwise MEM/WB under the same conditions.
  - sw store data is forwarded the same way.
- Branch compare in ID uses register-file values. No forwarding into ID is required; the program must provide spacing.
- Load-use hazard: ID/EX is lw and its rt equals the rs or rt of the instruction in IF/ID. Response:
  - hold PC and IF/ID for one cycle;
  - insert a bubble into ID/EX by zeroing all control bits.
- Flush: a taken beq or a j in ID loads PC with the target and replaces IF/ID with a NOP. There is exactly one lost slot; no delay slot executes.

## Timing
- Reset (rst_i low, asynchronous): PC = 0; all pipeline registers cleared to NOP with zero controls. Register file and memories are not cleared by reset; contents are bench-loaded.
- start_i low: PC holds. Pipeline registers still clock, so in-flight instructions drain.
- Fetch-to-writeback latency is 5 cycles. A result is visible in Registers 5 edges after fetch.
- Forwarding gives zero penalty for back-to-back ALU dependencies. A load-use pair costs exactly 1 stall cycle.
- A taken branch or a jump costs 1 cycle.
- Stall and flush in the same cycle: flush wins and PC takes the target. The stall condition itself is not raised for j or beq in ID.
- Data-memory write occurs at the clock edge in MEM. A read is combinational within MEM.
- PC increments by 4 and wraps modulo 2^32. Instruction index wraps modulo 256.

## Test plan
- Reset and hold: rst_i low, then high with start_i=0 -> PC stays 0 and all registers are unchanged. Raise start_i -> PC = 4, 8, 12 on successive edges.
- ALU with forwarding: addi $8,$0,5; addi $9,$8,3; sub $10,$9,$8; mul $11,$9,$8 back-to-back -> t0=5, t1=8, t2=3, t3=40 with no stall.
- Load-use: memory[0]=5; lw $8,0($0); add $9,$8,$8 -> exactly 1 stall cycle, t1=10. PC holds one cycle during the stall.
- Store: addi $8,$0,300; sw $8,4($0) -> bytes 4..7 = 0x2C, 0x01, 0x00, 0x00, so word 0x04 = 300.
- Branch: beq $0,$0,+2 taken -> the instruction after beq is flushed (its destination is unchanged), execution resumes at PC+4+8, and exactly 1 cycle is lost. A not-taken beq loses no cycles.
- Jump: j 0x10 at PC 0 -> next executed PC = 0x40, and the fetched instruction at PC 4 is squashed.

Source files
------------

// File: rtl/pipelined_cpu.sv
// pipelined_cpu: five-stage in-order MIPS-subset core (IF, ID, EX, MEM, WB).
// Instruction memory, data memory and register file are internal and are
// preloaded and inspected hierarchically. Hazards: EX-stage forwarding,
// one-cycle load-use stall, branch/jump resolution in ID with a one-slot
// flush.
//
// Ports:
//   clk_i   - system clock, rising edge
//   rst_i   - asynchronous active-low reset (PC and pipeline control)
//   start_i - run enable; PC advances only while high
//
// Submodules (same file): pc_reg (instance PC), instr_mem
// (Instruction_Memory), reg_file (Registers), data_mem (Data_Memory).

module pc_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  output logic [31:0] pc_o
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_o <= '0;
    else        pc_o <= pc_next;
  end
endmodule

module instr_mem (
  input  logic [7:0]  addr,
  output logic [31:0] instr
);
  logic [31:0] memory [0:255];
  assign instr = memory[addr];
endmodule

// Write at the clock edge; a same-cycle read of the register being written
// returns the new value, and r0 always reads zero.
module reg_file (
  input  logic        clk,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] register [0:31];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) register[wa] <= wd;
  end

  always_comb begin
    rd1 = register[ra1];
    rd2 = register[ra2];
    if (we && wa != 5'd0 && wa == ra1) rd1 = wd;
    if (we && wa != 5'd0 && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end
endmodule

// Byte-addressed little-endian word memory; the 5-bit byte index wraps.
module data_mem (
  input  logic        clk,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata
);
  logic [7:0] memory [0:31];
  logic [4:0] a1, a2, a3;

  assign a1 = addr + 5'd1;
  assign a2 = addr + 5'd2;
  assign a3 = addr + 5'd3;
  assign rdata = {memory[a3], memory[a2], memory[a1], memory[addr]};

  always_ff @(posedge clk) begin
    if (we) begin
      memory[addr] <= wdata[7:0];
      memory[a1]   <= wdata[15:8];
      memory[a2]   <= wdata[23:16];
      memory[a3]   <= wdata[31:24];
    end
  end
endmodule

module pipelined_cpu (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i
);
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_t;

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic signed [DATA_W-1:0] alu_calc(input alu_op_t op,
                                                        input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_MUL: return a * b;
      default: return a + b;
    endcase
  endfunction

  // IF
  logic [31:0] pc, pc_next, pc_plus4, instr_if;

  // IF/ID
  logic [31:0] instr_p1, pc_plus4_p1;
  logic        vld_p1;

  // ID
  logic [5:0]  op_id, funct_id;
  logic [4:0]  rs_id, rt_id, rd_id, dst_id;
  logic signed [DATA_W-1:0] imm_id, rd1_id, rd2_id;
  logic        reg_write_id, mem_read_id, mem_write_id, mem_to_reg_id, alu_src_id;
  logic        branch_id, jump_id, taken_id, flush, stall;
  alu_op_t     alu_op_id;
  logic [31:0] target_id;
  logic        unused_shamt;

  // ID/EX
  logic        reg_write_p2, mem_read_p2, mem_write_p2, mem_to_reg_p2, alu_src_p2, vld_p2;
  alu_op_t     alu_op_p2;
  logic [4:0]  rs_p2, rt_p2, dst_p2;
  logic signed [DATA_W-1:0] rd1_p2, rd2_p2, imm_p2;

  // EX
  logic signed [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_ex;

  // EX/MEM
  logic        reg_write_p3, mem_write_p3, mem_to_reg_p3, vld_p3;
  logic [4:0]  dst_p3;
  logic signed [DATA_W-1:0] alu_p3, store_p3;

  // MEM
  logic [31:0] mem_rdata;

  // MEM/WB
  logic        reg_write_p4, mem_to_reg_p4, vld_p4;
  logic [4:0]  dst_p4;
  logic signed [DATA_W-1:0] alu_p4, mem_p4, wb_data;

  // ---------------- IF stage ----------------
  assign pc_plus4 = pc + 32'd4;

  // Redirect wins over stall; a redirect is honoured even with start low so
  // a taken branch draining out of ID is not lost.
  always_comb begin
    pc_next = pc;
    if (flush)                 pc_next = target_id;
    else if (!stall && start_i) pc_next = pc_plus4;
  end

  pc_reg PC (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .pc_next (pc_next),
    .pc_o    (pc)
  );

  instr_mem Instruction_Memory (
    .addr  (pc[9:2]),
    .instr (instr_if)
  );

  // ---------------- IF/ID boundary ----------------
  // With start low nothing new is fetched, so a NOP enters and the pipe drains.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
    end else if (flush || (!stall && !start_i)) begin
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
    end else if (!stall) begin
      instr_p1 <= instr_if;
      vld_p1   <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!stall) pc_plus4_p1 <= pc_plus4;
  end

  // ---------------- ID stage ----------------
  assign op_id    = instr_p1[31:26];
  assign rs_id    = instr_p1[25:21];
  assign rt_id    = instr_p1[20:16];
  assign rd_id    = instr_p1[15:11];
  assign funct_id = instr_p1[5:0];
  assign imm_id   = sext16(instr_p1[15:0]);
  assign unused_shamt = ^instr_p1[10:6];

  always_comb begin
    reg_write_id  = 1'b0;
    mem_read_id   = 1'b0;
    mem_write_id  = 1'b0;
    mem_to_reg_id = 1'b0;
    alu_src_id    = 1'b0;
    dst_id        = rt_id;
    alu_op_id     = ALU_ADD;
    branch_id     = 1'b0;
    jump_id       = 1'b0;
    if (vld_p1) begin
      case (op_id)
        6'h00: begin
          dst_id       = rd_id;
          reg_write_id = 1'b1;
          case (funct_id)
            6'h20:   alu_op_id = ALU_ADD;
            6'h22:   alu_op_id = ALU_SUB;
            6'h24:   alu_op_id = ALU_AND;
            6'h25:   alu_op_id = ALU_OR;
            6'h18:   alu_op_id = ALU_MUL;
            default: reg_write_id = 1'b0;
          endcase
        end
        6'h08: begin
          reg_write_id = 1'b1;
          alu_src_id   = 1'b1;
        end
        6'h23: begin
          reg_write_id  = 1'b1;
          mem_read_id   = 1'b1;
          mem_to_reg_id = 1'b1;
          alu_src_id    = 1'b1;
        end
        6'h2B: begin
          mem_write_id = 1'b1;
          alu_src_id   = 1'b1;
        end
        6'h04:   branch_id = 1'b1;
        6'h02:   jump_id   = 1'b1;
        default: ;
      endcase
    end
  end

  reg_file Registers (
    .clk (clk_i),
    .ra1 (rs_id),
    .ra2 (rt_id),
    .wa  (dst_p4),
    .wd  (wb_data),
    .we  (reg_write_p4 && vld_p4),
    .rd1 (rd1_id),
    .rd2 (rd2_id)
  );

  assign taken_id  = branch_id && (rd1_id == rd2_id);
  assign flush     = jump_id || taken_id;
  assign target_id = jump_id ? {pc_plus4_p1[31:28], instr_p1[25:0], 2'b00}
                             : pc_plus4_p1 + {imm_id[29:0], 2'b00};

  // j and beq fields alias rs/rt, so they never raise the load-use stall.
  assign stall = mem_read_p2 && !branch_id && !jump_id &&
                 (rt_p2 == rs_id || rt_p2 == rt_id);

  // ---------------- ID/EX boundary ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i || stall) begin
      reg_write_p2  <= 1'b0;
      mem_read_p2   <= 1'b0;
      mem_write_p2  <= 1'b0;
      mem_to_reg_p2 <= 1'b0;
      alu_src_p2    <= 1'b0;
      alu_op_p2     <= ALU_ADD;
      vld_p2        <= 1'b0;
    end else begin
      reg_write_p2  <= reg_write_id;
      mem_read_p2   <= mem_read_id;
      mem_write_p2  <= mem_write_id;
      mem_to_reg_p2 <= mem_to_reg_id;
      alu_src_p2    <= alu_src_id;
      alu_op_p2     <= alu_op_id;
      vld_p2        <= vld_p1;
    end
  end

  always_ff @(posedge clk_i) begin
    rs_p2  <= rs_id;
    rt_p2  <= rt_id;
    dst_p2 <= dst_id;
    rd1_p2 <= rd1_id;
    rd2_p2 <= rd2_id;
    imm_p2 <= imm_id;
  end

  // ---------------- EX stage ----------------
  always_comb begin
    fwd_a = rd1_p2;
    if (reg_write_p3 && dst_p3 != 5'd0 && dst_p3 == rs_p2)      fwd_a = alu_p3;
    else if (reg_write_p4 && dst_p4 != 5'd0 && dst_p4 == rs_p2) fwd_a = wb_data;
    fwd_b = rd2_p2;
    if (reg_write_p3 && dst_p3 != 5'd0 && dst_p3 == rt_p2)      fwd_b = alu_p3;
    else if (reg_write_p4 && dst_p4 != 5'd0 && dst_p4 == rt_p2) fwd_b = wb_data;
  end

  assign alu_b  = alu_src_p2 ? imm_p2 : fwd_b;
  assign alu_ex = alu_calc(alu_op_p2, fwd_a, alu_b);

  // ---------------- EX/MEM boundary ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_write_p3  <= 1'b0;
      mem_write_p3  <= 1'b0;
      mem_to_reg_p3 <= 1'b0;
      vld_p3        <= 1'b0;
    end else begin
      reg_write_p3  <= reg_write_p2;
      mem_write_p3  <= mem_write_p2;
      mem_to_reg_p3 <= mem_to_reg_p2;
      vld_p3        <= vld_p2;
    end
  end

  always_ff @(posedge clk_i) begin
    dst_p3   <= dst_p2;
    alu_p3   <= alu_ex;
    store_p3 <= fwd_b;
  end

  // ---------------- MEM stage ----------------
  data_mem Data_Memory (
    .clk   (clk_i),
    .addr  (alu_p3[4:0]),
    .wdata (store_p3),
    .we    (mem_write_p3 && vld_p3),
    .rdata (mem_rdata)
  );

  // ---------------- MEM/WB boundary ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_write_p4  <= 1'b0;
      mem_to_reg_p4 <= 1'b0;
      vld_p4        <= 1'b0;
    end else begin
      reg_write_p4  <= reg_write_p3;
      mem_to_reg_p4 <= mem_to_reg_p3;
      vld_p4        <= vld_p3;
    end
  end

  always_ff @(posedge clk_i) begin
    dst_p4 <= dst_p3;
    alu_p4 <= alu_p3;
    mem_p4 <= mem_rdata;
  end

  // ---------------- WB stage ----------------
  assign wb_data = mem_to_reg_p4 ? mem_p4 : alu_p4;

endmodule

// File: tb/tb_pipelined_cpu.sv
module tb_pipelined_cpu;
  logic clk_i = 1'b0;
  logic rst_i;
  logic start_i;

  always #5 clk_i = ~clk_i;

  pipelined_cpu dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] enc_r(input logic [5:0] funct, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] addr);
    return {6'h02, addr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic run(input int n);
    start_i = 1'b1;
    repeat (n) tick();
  endtask

  task automatic do_reset;
    start_i = 1'b0;
    rst_i   = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
    for (int i = 0; i < 32; i++)  dut.Data_Memory.memory[i] = 8'h0;
    dut.Registers.register[0] = 32'h0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    vecs[0] = '{32'd7,        32'd5,        enc_r(6'h20, 5'd1, 5'd2, 5'd3), 5'd3, 32'd12};
    vecs[1] = '{32'd5,        32'd7,        enc_r(6'h22, 5'd1, 5'd2, 5'd3), 5'd3, 32'hFFFF_FFFE};
    vecs[2] = '{32'hF0F0F0F0, 32'hFF00FF00, enc_r(6'h24, 5'd1, 5'd2, 5'd3), 5'd3, 32'hF000_F000};
    vecs[3] = '{32'hF0F0F0F0, 32'hFF00FF00, enc_r(6'h25, 5'd1, 5'd2, 5'd3), 5'd3, 32'hFFF0_FFF0};
    vecs[4] = '{32'h0001_0000, 32'h0001_0003, enc_r(6'h18, 5'd1, 5'd2, 5'd3), 5'd3, 32'h0003_0000};
    vecs[5] = '{32'hFFFF_FFFD, 32'd7,       enc_r(6'h18, 5'd1, 5'd2, 5'd3), 5'd3, 32'hFFFF_FFEB};
    vecs[6] = '{32'd0,        32'd0,        enc_i(6'h08, 5'd1, 5'd3, 16'hFFFF), 5'd3, 32'hFFFF_FFFF};
    vecs[7] = '{32'd0,        32'd0,        enc_i(6'h08, 5'd0, 5'd0, 16'd5), 5'd0, 32'd0};
    vecs[8] = '{32'd1,        32'd2,        enc_i(6'h0D, 5'd1, 5'd3, 16'h00FF), 5'd3, 32'hA5A5_A5A5};
    vecs[9] = '{32'h7FFF_FFFF, 32'd1,       enc_r(6'h20, 5'd1, 5'd2, 5'd3), 5'd3, 32'h8000_0000};

    // Reset and hold with start low, then PC sequence and async reset.
    do_reset();
    dut.Registers.register[8] = 32'hDEAD_BEEF;
    dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd1);
    check("reset_pc", dut.PC.pc_o, 32'h0);
    repeat (4) tick();
    check("hold_pc", dut.PC.pc_o, 32'h0);
    check("hold_reg", dut.Registers.register[8], 32'hDEAD_BEEF);
    run(1); check("run_pc4", dut.PC.pc_o, 32'd4);
    run(1); check("run_pc8", dut.PC.pc_o, 32'd8);
    run(1); check("run_pc12", dut.PC.pc_o, 32'd12);
    rst_i = 1'b0;
    #1;
    check("async_reset_pc", dut.PC.pc_o, 32'h0);

    // Single-instruction table.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      dut.Registers.register[1] = vecs[i].a;
      dut.Registers.register[2] = vecs[i].b;
      dut.Registers.register[3] = 32'hA5A5_A5A5;
      dut.Instruction_Memory.memory[0] = vecs[i].instr;
      run(8);
      check($sformatf("vec%0d", i), dut.Registers.register[vecs[i].rd], vecs[i].exp);
    end

    // Back-to-back ALU chain through forwarding.
    do_reset();
    dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
    dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd8, 5'd9, 16'd3);
    dut.Instruction_Memory.memory[2] = enc_r(6'h22, 5'd9, 5'd8, 5'd10);
    dut.Instruction_Memory.memory[3] = enc_r(6'h18, 5'd9, 5'd8, 5'd11);
    run(4);
    check("fwd_no_stall_pc", dut.PC.pc_o, 32'd16);
    run(6);
    check("fwd_t0", dut.Registers.register[8], 32'd5);
    check("fwd_t1", dut.Registers.register[9], 32'd8);
    check("fwd_t2", dut.Registers.register[10], 32'd3);
    check("fwd_t3", dut.Registers.register[11], 32'd40);

    // Load-use: one stall cycle, PC holds once.
    do_reset();
    dut.Data_Memory.memory[0] = 8'd5;
    dut.Instruction_Memory.memory[0] = enc_i(6'h23, 5'd0, 5'd8, 16'd0);
    dut.Instruction_Memory.memory[1] = enc_r(6'h20, 5'd8, 5'd8, 5'd9);
    run(1); check("lu_pc_e1", dut.PC.pc_o, 32'd4);
    run(1); check("lu_pc_e2", dut.PC.pc_o, 32'd8);
    run(1); check("lu_pc_stall", dut.PC.pc_o, 32'd8);
    run(1); check("lu_pc_resume", dut.PC.pc_o, 32'd12);
    run(6);
    check("lu_t0", dut.Registers.register[8], 32'd5);
    check("lu_t1", dut.Registers.register[9], 32'd10);

    // Store with forwarded data.
    do_reset();
    dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd300);
    dut.Instruction_Memory.memory[1] = enc_i(6'h2B, 5'd0, 5'd8, 16'd4);
    run(8);
    check("st_b4", {24'h0, dut.Data_Memory.memory[4]}, 32'h2C);
    check("st_b5", {24'h0, dut.Data_Memory.memory[5]}, 32'h01);
    check("st_b6", {24'h0, dut.Data_Memory.memory[6]}, 32'h00);
    check("st_b7", {24'h0, dut.Data_Memory.memory[7]}, 32'h00);
    check("st_word", {dut.Data_Memory.memory[7], dut.Data_Memory.memory[6],
                      dut.Data_Memory.memory[5], dut.Data_Memory.memory[4]}, 32'd300);

    // Taken beq: one slot flushed, resume at PC+4+8.
    do_reset();
    for (int r = 9; r <= 11; r++) dut.Registers.register[r] = 32'h55;
    dut.Instruction_Memory.memory[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
    dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd0, 5'd9, 16'd7);
    dut.Instruction_Memory.memory[2] = enc_i(6'h08, 5'd0, 5'd10, 16'd9);
    dut.Instruction_Memory.memory[3] = enc_i(6'h08, 5'd0, 5'd11, 16'd11);
    run(1); check("beq_pc_e1", dut.PC.pc_o, 32'd4);
    run(1); check("beq_pc_target", dut.PC.pc_o, 32'd12);
    run(1); check("beq_pc_next", dut.PC.pc_o, 32'd16);
    run(8);
    check("beq_flushed", dut.Registers.register[9], 32'h55);
    check("beq_skipped", dut.Registers.register[10], 32'h55);
    check("beq_target_exec", dut.Registers.register[11], 32'd11);

    // Not-taken beq: no cycles lost.
    do_reset();
    dut.Registers.register[1] = 32'd1;
    dut.Registers.register[9] = 32'h55;
    dut.Registers.register[10] = 32'h55;
    dut.Instruction_Memory.memory[0] = enc_i(6'h04, 5'd0, 5'd1, 16'd2);
    dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd0, 5'd9, 16'd7);
    dut.Instruction_Memory.memory[2] = enc_i(6'h08, 5'd0, 5'd10, 16'd9);
    run(1); check("bnt_pc_e1", dut.PC.pc_o, 32'd4);
    run(1); check("bnt_pc_e2", dut.PC.pc_o, 32'd8);
    run(1); check("bnt_pc_e3", dut.PC.pc_o, 32'd12);
    run(8);
    check("bnt_r9", dut.Registers.register[9], 32'd7);
    check("bnt_r10", dut.Registers.register[10], 32'd9);

    // Jump: target 0x40, slot at PC 4 squashed.
    do_reset();
    dut.Registers.register[9] = 32'h55;
    dut.Registers.register[10] = 32'h55;
    dut.Instruction_Memory.memory[0]  = enc_j(26'h10);
    dut.Instruction_Memory.memory[1]  = enc_i(6'h08, 5'd0, 5'd9, 16'd7);
    dut.Instruction_Memory.memory[16] = enc_i(6'h08, 5'd0, 5'd10, 16'd9);
    run(1); check("j_pc_e1", dut.PC.pc_o, 32'd4);
    run(1); check("j_pc_target", dut.PC.pc_o, 32'h40);
    run(1); check("j_pc_next", dut.PC.pc_o, 32'h44);
    run(8);
    check("j_squashed", dut.Registers.register[9], 32'h55);
    check("j_target_exec", dut.Registers.register[10], 32'd9);

    start_i = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
